// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, the word
// width and the special instruction encodings used by the fetch stage.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned; drop the byte offset.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational instruction memory (slave).
interface if_fetch_stage_if;
    import mips_pkg::*;

    logic [WORD_W-1:0] imem_addr;   // word address
    logic [WORD_W-1:0] imem_instr;  // instruction returned for imem_addr

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/if_id_reg.sv
// Pipeline register between two stages: holds on hold, loads a bubble
// (NOP, invalid) on flush, otherwise captures the incoming instruction.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_p0,
    input  logic [WORD_W-1:0] pc4_p0,
    output logic [WORD_W-1:0] instr_p1,
    output logic [WORD_W-1:0] pc4_p1,
    output logic              vld_p1
);

    // Stage p0 -> p1: flush beats hold so a squashed slot never survives a stall
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (!hold) begin
            instr_p1 <= instr_p0;
            pc4_p1   <= pc4_p0;
            vld_p1   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory
// and fills the IF/ID register. Controlled by stall, redirect and halt.
// Optional build macro IF_PERF_CNT_EN adds fetch/bubble counters.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int                MEM_AW     = 6,
    parameter logic [WORD_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    if_fetch_stage_if.master  imem,
    output logic [WORD_W-1:0] ifid_instr_o,
    output logic [WORD_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic [WORD_W-1:0] pc_o,
    output logic              halted_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_cnt_o,
    output logic [WORD_W-1:0] bubble_cnt_o
`endif
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc4_p0;
    logic              hold, flush;

    assign pc4_p0         = pc_q + 32'd4;
    assign imem.imem_addr = {{(WORD_W-MEM_AW){1'b0}}, pc_q[MEM_AW+1:2]};
    assign pc_o           = pc_q;
    assign halted_o       = (state_q == ST_HALT);

    // State and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID control; redirect > stall > fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                hold    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    pc_d  = align_word(redirect_pc_i);
                    flush = 1'b1;
                end else if (stall_i) begin
                    hold = 1'b1;
                end else begin
                    pc_d = pc4_p0;
                    if (imem.imem_instr == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (redirect_i) begin
                    pc_d    = align_word(redirect_pc_i);
                    state_d = ST_RUN;
                end
            end
            default: begin
                hold    = 1'b1;
                state_d = ST_BOOT;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .flush    (flush),
        .instr_p0 (imem.imem_instr),
        .pc4_p0   (pc4_p0),
        .instr_p1 (ifid_instr_o),
        .pc4_p1   (ifid_pc4_o),
        .vld_p1   (ifid_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic fetch_inc, bubble_inc;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign fetch_inc  = (state_q == ST_RUN) && !redirect_i && !stall_i;
    assign bubble_inc = ((state_q == ST_RUN) && (redirect_i || stall_i)) ||
                        ((state_q == ST_HALT) && redirect_i);

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (fetch_inc)  fetch_cnt_o  <= sat_inc(fetch_cnt_o);
            if (bubble_inc) bubble_cnt_o <= sat_inc(bubble_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: table of per-cycle vectors with expected
// post-edge outputs, pushed to a scoreboard queue when driven and popped
// after the clock edge.
module tb_if_fetch_stage;

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h2002_0003;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] W4 = 32'h8C04_0000;
    localparam logic [31:0] HL = 32'hFFFF_FFFF;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        halted;
        logic [31:0] addr;
        int          perf;   // 0 none, 1 fetch, 2 bubble, 3 reset
        int          fcnt;
        int          bcnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic [31:0] pc_o;
    logic        halted_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    logic [31:0] mem [64];
    vec_t        tbl[$];
    vec_t        exp_q[$];
    int          vectors;
    int          miscompares;
    int          model_f;
    int          model_b;

    if_fetch_stage_if bus ();

    assign bus.imem_instr = mem[bus.imem_addr[5:0]];

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .MEM_AW     (6),
        .HALT_INSTR (32'hFFFF_FFFF),
        .NOP_INSTR  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .pc_o          (pc_o),
        .halted_o      (halted_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic d, input logic [31:0] rp,
                       input logic [31:0] pc, input logic v, input logic [31:0] ins,
                       input logic [31:0] p4, input logic cp, input logic h,
                       input logic [31:0] a, input int pf);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = d; t.rpc = rp;
        t.pc = pc; t.vld = v; t.instr = ins; t.pc4 = p4; t.chk_pc4 = cp;
        t.halted = h; t.addr = a; t.perf = pf; t.fcnt = 0; t.bcnt = 0;
        tbl.push_back(t);
    endtask

    task automatic chk(input int row, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL row%0d %s: got %h, expected %h", row, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expectation, compare after the edge
    task automatic apply(input int row, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        case (v.perf)
            1: model_f++;
            2: model_b++;
            3: begin model_f = 0; model_b = 0; end
            default: ;
        endcase
        v.fcnt = model_f;
        v.bcnt = model_b;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        chk(row, "pc",     pc_o,                 e.pc);
        chk(row, "valid",  {31'b0, ifid_valid_o}, {31'b0, e.vld});
        chk(row, "instr",  ifid_instr_o,         e.instr);
        chk(row, "halted", {31'b0, halted_o},    {31'b0, e.halted});
        chk(row, "addr",   bus.imem_addr,        e.addr);
        if (e.chk_pc4) chk(row, "pc4", ifid_pc4_o, e.pc4);
`ifdef IF_PERF_CNT_EN
        chk(row, "fetch_cnt",  fetch_cnt_o,  32'(e.fcnt));
        chk(row, "bubble_cnt", bubble_cnt_o, 32'(e.bcnt));
`endif
    endtask

    initial begin
        vec_t        hv;
        logic [5:0]  idx;
        vectors     = 0;
        miscompares = 0;
        model_f     = 0;
        model_b     = 0;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = 32'h0000_0000;
        mem[4] = W4; mem[5] = HL;

        //   rst stl red rpc            pc            v  instr  pc4           cp h  addr pf
        add(1, 0, 0, 32'h0,          32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  3); // reset
        add(0, 0, 0, 32'h0,          32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  0); // BOOT
        add(0, 0, 0, 32'h0,          32'h4,         1, W0,    32'h4,        1, 0, 1,  1);
        add(0, 0, 0, 32'h0,          32'h8,         1, W1,    32'h8,        1, 0, 2,  1);
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 32'h0,      32'h8,         1, W1,    32'h8,        1, 0, 2,  2); // stall
        add(0, 0, 0, 32'h0,          32'hC,         1, W2,    32'hC,        1, 0, 3,  1);
        add(0, 1, 1, 32'h13,         32'h10,        0, 32'h0, 32'h0,        0, 0, 4,  2); // redirect+stall
        add(0, 0, 0, 32'h0,          32'h14,        1, W4,    32'h14,       1, 0, 5,  1);
        add(0, 0, 0, 32'h0,          32'h18,        1, HL,    32'h18,       1, 1, 6,  1); // halt captured
        for (int k = 0; k < 10; k++)
            add(0, logic'(k % 2), 0, 32'h0, 32'h18,  0, 32'h0, 32'h0,        0, 1, 6,  0); // halted
        add(0, 0, 1, 32'h0,          32'h0,         0, 32'h0, 32'h0,        0, 0, 0,  2); // leave HALT
        add(0, 0, 0, 32'h0,          32'h4,         1, W0,    32'h4,        1, 0, 1,  1);
        add(0, 0, 0, 32'h0,          32'h8,         1, W1,    32'h8,        1, 0, 2,  1);
        add(0, 1, 0, 32'h0,          32'h8,         1, W1,    32'h8,        1, 0, 2,  2);
        add(1, 1, 0, 32'h0,          32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  3); // rst mid-stall
        add(0, 1, 1, 32'h40,         32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  0); // BOOT ignores
        add(0, 0, 0, 32'h0,          32'h4,         1, W0,    32'h4,        1, 0, 1,  1);
        add(0, 0, 1, 32'h14,         32'h14,        0, 32'h0, 32'h0,        0, 0, 5,  2);
        add(0, 0, 0, 32'h0,          32'h18,        1, HL,    32'h18,       1, 1, 6,  1);
        add(0, 0, 0, 32'h0,          32'h18,        0, 32'h0, 32'h0,        0, 1, 6,  0);
        add(1, 0, 0, 32'h0,          32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  3); // rst in HALT
        add(0, 0, 0, 32'h0,          32'h0,         0, 32'h0, 32'h0,        1, 0, 0,  0); // BOOT
        add(0, 0, 1, 32'hFC,         32'hFC,        0, 32'h0, 32'h0,        0, 0, 63, 2);
        add(0, 0, 0, 32'h0,          32'h100,       1, 32'h1000_003F, 32'h100, 1, 0, 0, 1); // addr wrap
        add(0, 0, 0, 32'h0,          32'h104,       1, W0,    32'h104,      1, 0, 1,  1);
        add(0, 0, 1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 0, 32'h0, 32'h0,        0, 0, 63, 2);
        add(0, 0, 0, 32'h0,          32'h0,         1, 32'h1000_003F, 32'h0, 1, 0, 0,  1); // pc wrap

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Hand-written sequence: redirect near the top of memory, then fetch
        // across the address wrap, expectations taken from the memory image.
        hv = tbl[0];
        hv.rst = 0; hv.stall = 0; hv.redir = 1; hv.rpc = 32'hF8;
        hv.pc = 32'hF8; hv.vld = 0; hv.instr = 32'h0; hv.chk_pc4 = 0;
        hv.halted = 0; hv.addr = 32'd62; hv.perf = 2;
        apply(100, hv);
        for (int k = 0; k < 4; k++) begin
            idx        = 6'(62 + k);
            hv.redir   = 0;
            hv.rpc     = 32'h0;
            hv.vld     = 1;
            hv.instr   = mem[idx];
            hv.pc      = 32'hF8 + 32'(4 * (k + 1));
            hv.pc4     = hv.pc;
            hv.chk_pc4 = 1;
            hv.addr    = {26'b0, 6'(idx + 6'd1)};
            hv.perf    = 1;
            apply(101 + k, hv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It is the reader/initiator for the combinational instruction memory. It owns the PC, drives the word address to instruction memory, and captures the returned instruction into the IF/ID pipeline register. Downstream stages control it through stall, redirect (branch/jump) and halt.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
MEM_AW, 6, instruction-memory word-address width (64 words)
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch
NOP_INSTR, 32'h0000_0000, value loaded into IF/ID on a bubble

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC and IF/ID (hazard from ID)
redirect_i  in  1  branch/jump taken; flush and load new PC
redirect_pc_i  in  32  byte target address
imem_addr_o  out  32  word address to instruction memory
imem_instr_i  in  32  instruction returned combinationally for imem_addr_o
ifid_instr_o  out  32  IF/ID instruction
ifid_pc4_o  out  32  IF/ID PC+4 of captured instruction
ifid_valid_o  out  1  IF/ID holds a real instruction
pc_o  out  32  current PC (byte address)
halted_o  out  1  fetch stopped on HALT_INSTR

Behaviour:
- The reset is synchronous: at a posedge clk with rst=1, pc=RESET_PC, state=BOOT, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, halted_o=0. Reset overrides every other input, including mid-stall and mid-redirect.
- imem_addr_o = zero-extended pc[MEM_AW+1:2], combinational from the pc register. Addresses beyond the memory wrap modulo 2^MEM_AW words.
- Latency: an instruction at PC p appears on ifid_* one cycle after pc=p, with ifid_pc4=p+4 (32-bit wrap).
- FSM states:
  - BOOT: one cycle. No capture, ifid_valid stays 0, PC unchanged. Next state is RUN.
  - RUN: normal fetch.
  - HALT: PC frozen. ifid_valid=0 with NOP_INSTR loaded on every cycle. halted_o=1.
- Priority within RUN, highest first:
  1. redirect_i: pc<=redirect_pc_i & ~32'h3 (low bits forced to 0), IF/ID bubble (NOP_INSTR, valid=0). redirect wins over a simultaneous stall_i.
  2. stall_i: pc and all ifid_* hold their values.
  3. Otherwise: capture imem_instr_i, pc<=pc+4, valid=1.
     - If the captured instruction equals HALT_INSTR, it is still passed with valid=1 and the next state is HALT.
- In HALT, redirect_i returns to RUN with the new PC. This covers a wrong-path halt that a later branch squashes. stall_i has no effect in HALT.
- In BOOT, redirect_i and stall_i are ignored.
- pc_o equals the pc register. The PC wraps from 32'hFFFF_FFFC to 0.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output ports fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both cleared by rst and saturating at all-ones.
  - fetch_cnt_o increments on every cycle in which valid=1 is captured.
  - bubble_cnt_o increments on every redirect flush and every stalled RUN cycle.
- Undefined: these ports and their logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - the state encoding (BOOT/RUN/HALT, 2 bits)
  - the NOP_INSTR and HALT_INSTR constants
  - the RESET_PC default
  - the 32-bit word-width constant
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold, flush-to-NOP and valid bit. The same register pattern is reused for later pipeline registers.

Test Plan:
- Reset release with memory words 0..3 = 0x20010005, 0x20020003, 0x00221820, 0x00000000:
  - BOOT cycle: ifid_valid=0.
  - Then ifid_instr follows word0, word1, word2 on consecutive cycles with ifid_pc4 = 4, 8, 12.
- stall_i=1 for 3 cycles while ifid holds word1: pc_o stays 8, ifid_instr stays 0x20020003, valid stays 1. Fetch resumes with word2.
- redirect_i=1 with redirect_pc_i=0x0000_0013 together with stall_i=1:
  - Next cycle: pc_o=0x10, ifid_valid=0, ifid_instr=0.
  - The following cycle captures word4 with ifid_pc4=0x14.
- Word5 = 0xFFFF_FFFF: it is captured with valid=1, then halted_o=1, ifid_valid=0 and pc_o frozen at 0x18 for 10 cycles. A redirect to 0x0 then resumes fetch at word0.
- Assert rst during stall and during HALT: next cycle all outputs are at reset values and pc_o=RESET_PC.
- pc=0x0000_00FC with MEM_AW=6: imem_addr_o=63; next pc=0x100 gives imem_addr_o=0 (wrap). With IF_PERF_CNT_EN defined, fetch_cnt_o and bubble_cnt_o match scoreboard counts.
